// File: rtl/spi_cmd_ctrl.sv
// Command controller sitting behind an SPI slave: decodes register/long-payload commands and sequences replies.
// Optional long-payload timeout is compiled in with `define SPI_CMD_TIMEOUT_EN.
module spi_cmd_ctrl #(
  parameter int TMO_CYCLES = 1000000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         received,
  input  logic [47:0]  received_data,
  input  logic [127:0] long_dataIN,
  input  logic         busy,
  input  logic [7:0]   stat_in,
  output logic         send_trigger,
  output logic [2:0]   SPI_MSG_TYPE,
  output logic [127:0] output_data,
  output logic         LongMsgComing,
  output logic [6:0]   InMsgByteCount,
  output logic [63:0]  reg_out,
  output logic [7:0]   err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_WAIT_LONG = 3'd2,
    S_TRIG      = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_WAIT_DONE = 3'd5
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [15:0]  r_cmd, w_cmd_nxt;
  logic         r_trig, w_trig_nxt;
  logic [2:0]   r_type, w_type_nxt;
  logic [127:0] r_out, w_out_nxt;
  logic         r_lmc, w_lmc_nxt;
  logic [6:0]   r_ibc, w_ibc_nxt;
  logic [63:0]  r_regs, w_regs_nxt;
  logic [7:0]   r_err, w_err_nxt;
  logic [127:0] r_lbuf, w_lbuf_nxt;
  logic [4:0]   r_lcnt, w_lcnt_nxt;
`ifdef SPI_CMD_TIMEOUT_EN
  logic [19:0]  r_tmo, w_tmo_nxt;
`endif

  logic [3:0] w_opc;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic [4:0] w_n;
  logic       w_n_ok;
  logic [7:0] w_rk;
  logic       w_err_ev;
  logic       w_to_idle;
  logic       w_drop;
  logic       w_unused;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  function automatic logic [127:0] keep_bytes(input logic [127:0] d, input logic [4:0] n);
    logic [127:0] m;
    m = d;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) >= n) m[8*i +: 8] = 8'h00;
      else            m[8*i +: 8] = d[8*i +: 8];
    end
    return m;
  endfunction

  assign w_opc    = r_cmd[15:12];
  assign w_addr   = r_cmd[10:8];
  assign w_data   = r_cmd[7:0];
  assign w_n      = r_cmd[4:0];
  assign w_n_ok   = (w_n != 5'd0) && (w_n <= 5'd16);
  assign w_rk     = r_regs[{w_addr, 3'b000} +: 8];
  assign w_unused = ^{received_data[47:16], r_cmd[11]};

  // Next-state and next-register computation for the command FSM
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_trig_nxt  = r_trig;
    w_type_nxt  = r_type;
    w_out_nxt   = r_out;
    w_lmc_nxt   = r_lmc;
    w_ibc_nxt   = r_ibc;
    w_regs_nxt  = r_regs;
    w_err_nxt   = r_err;
    w_lbuf_nxt  = r_lbuf;
    w_lcnt_nxt  = r_lcnt;
`ifdef SPI_CMD_TIMEOUT_EN
    w_tmo_nxt   = r_tmo;
`endif
    w_err_ev    = 1'b0;
    w_to_idle   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (received) begin
          w_cmd_nxt   = received_data[15:0];
          w_state_nxt = S_DECODE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DECODE: begin
        case (w_opc)
          4'h1: begin
            if (w_addr != 3'd7) w_regs_nxt[{w_addr, 3'b000} +: 8] = w_data;
            else                w_err_ev = 1'b1;
            w_to_idle = 1'b1;
          end
          4'h2: begin
            w_out_nxt   = {112'b0, 4'h2, 1'b0, w_addr, (w_addr == 3'd7) ? stat_in : w_rk};
            w_type_nxt  = 3'b010;
            w_state_nxt = S_TRIG;
          end
          4'h3: begin
            if (w_n_ok) begin
              w_lmc_nxt   = 1'b1;
              w_ibc_nxt   = {2'b00, w_n};
              w_state_nxt = S_WAIT_LONG;
`ifdef SPI_CMD_TIMEOUT_EN
              w_tmo_nxt   = 20'd0;
`endif
            end else begin
              w_err_ev  = 1'b1;
              w_to_idle = 1'b1;
            end
          end
          4'h4: begin
            if (r_lcnt == 5'd0) begin
              w_err_ev  = 1'b1;
              w_to_idle = 1'b1;
            end else begin
              w_out_nxt   = r_lbuf;
              w_type_nxt  = 3'b111;
              w_ibc_nxt   = {2'b00, r_lcnt};
              w_state_nxt = S_TRIG;
            end
          end
          default: begin
            w_err_ev  = 1'b1;
            w_to_idle = 1'b1;
          end
        endcase
      end
      S_WAIT_LONG: begin
        if (received) begin
          w_lbuf_nxt = keep_bytes(long_dataIN, w_n);
          w_lcnt_nxt = w_n;
          w_lmc_nxt  = 1'b0;
          w_to_idle  = 1'b1;
        end else begin
`ifdef SPI_CMD_TIMEOUT_EN
          if (r_tmo == 20'(TMO_CYCLES - 1)) begin
            w_lmc_nxt = 1'b0;
            w_err_ev  = 1'b1;
            w_to_idle = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo + 20'd1;
          end
`else
          w_state_nxt = S_WAIT_LONG;
`endif
        end
      end
      S_TRIG: begin
        if (!busy) begin
          w_trig_nxt  = 1'b1;
          w_state_nxt = S_WAIT_ACK;
        end else begin
          w_state_nxt = S_TRIG;
        end
      end
      S_WAIT_ACK: begin
        if (busy) begin
          w_trig_nxt  = 1'b0;
          w_state_nxt = S_WAIT_DONE;
        end else begin
          w_trig_nxt  = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!busy) w_to_idle   = 1'b1;
        else       w_state_nxt = S_WAIT_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A frame arriving on the very cycle we fall back to IDLE is taken as the next command
    if (w_to_idle) begin
      if (received && (r_state != S_WAIT_LONG)) begin
        w_cmd_nxt   = received_data[15:0];
        w_state_nxt = S_DECODE;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else begin
      w_cmd_nxt = w_cmd_nxt;
    end

    w_drop = received && !w_to_idle &&
             (r_state != S_IDLE) && (r_state != S_WAIT_LONG);

    if (w_err_ev || w_drop) w_err_nxt = sat_inc(r_err);
    else                    w_err_nxt = r_err;
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cmd   <= 16'h0000;
      r_trig  <= 1'b0;
      r_type  <= 3'b010;
      r_out   <= 128'd0;
      r_lmc   <= 1'b0;
      r_ibc   <= 7'd0;
      r_regs  <= 64'd0;
      r_err   <= 8'd0;
      r_lbuf  <= 128'd0;
      r_lcnt  <= 5'd0;
`ifdef SPI_CMD_TIMEOUT_EN
      r_tmo   <= 20'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_trig  <= w_trig_nxt;
      r_type  <= w_type_nxt;
      r_out   <= w_out_nxt;
      r_lmc   <= w_lmc_nxt;
      r_ibc   <= w_ibc_nxt;
      r_regs  <= w_regs_nxt;
      r_err   <= w_err_nxt;
      r_lbuf  <= w_lbuf_nxt;
      r_lcnt  <= w_lcnt_nxt;
`ifdef SPI_CMD_TIMEOUT_EN
      r_tmo   <= w_tmo_nxt;
`endif
    end
  end

  assign send_trigger   = r_trig;
  assign SPI_MSG_TYPE   = r_type;
  assign output_data    = r_out;
  assign LongMsgComing  = r_lmc;
  assign InMsgByteCount = r_ibc;
  assign reg_out        = r_regs;
  assign err_cnt        = r_err;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Randomized scoreboard bench for spi_cmd_ctrl with an emulated SPI slave busy handshake.
module tb_spi_cmd_ctrl;

  logic         CLK = 1'b0;
  logic         RST;
  logic         received;
  logic [47:0]  received_data;
  logic [127:0] long_dataIN;
  logic         busy;
  logic [7:0]   stat_in;
  logic         send_trigger;
  logic [2:0]   SPI_MSG_TYPE;
  logic [127:0] output_data;
  logic         LongMsgComing;
  logic [6:0]   InMsgByteCount;
  logic [63:0]  reg_out;
  logic [7:0]   err_cnt;

  always #5 CLK = ~CLK;

  spi_cmd_ctrl #(.TMO_CYCLES(100)) dut (
    .CLK(CLK), .RST(RST), .received(received), .received_data(received_data),
    .long_dataIN(long_dataIN), .busy(busy), .stat_in(stat_in),
    .send_trigger(send_trigger), .SPI_MSG_TYPE(SPI_MSG_TYPE), .output_data(output_data),
    .LongMsgComing(LongMsgComing), .InMsgByteCount(InMsgByteCount),
    .reg_out(reg_out), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [127:0] data;
    logic [2:0]   typ;
    logic [6:0]   cnt;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // reference model state
  logic [7:0]   m_regs [8];
  int           m_err;
  logic [127:0] m_lbuf;
  int           m_lcnt;
  int           m_ibc;

  bit   hold_busy_low = 1'b0;
  int   done_cnt = 0;
  logic mon_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_regout();
    logic [63:0] v;
    v = 64'd0;
    for (int k = 0; k < 8; k++) v = v | (64'(m_regs[k]) << (8 * k));
    return v;
  endfunction

  task automatic bump_err();
    m_err = (m_err < 255) ? m_err + 1 : 255;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_regs[k] = 8'h00;
    m_err  = 0;
    m_lbuf = 128'd0;
    m_lcnt = 0;
    m_ibc  = 0;
  endtask

  // one-cycle frame pulse; entered and left at posedge+1
  task automatic pulse(input logic [15:0] cmd);
    received_data = {32'($urandom()), cmd};
    received = 1'b1;
    @(posedge CLK); #1;
    received = 1'b0;
  endtask

  // Response monitor: every rising send_trigger must match the oldest expected reply
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK); #1;
      if (send_trigger && !mon_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_trigger: got send_trigger=1 expected no reply at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", output_data, e.data);
          chk("resp_type", 128'(SPI_MSG_TYPE), 128'(e.typ));
          chk("resp_cnt",  128'(InMsgByteCount), 128'(e.cnt));
        end
      end
      mon_prev = send_trigger;
    end
  end

  // SPI slave emulation: acknowledge a trigger with busy after a random delay
  initial begin
    int d;
    busy = 1'b0;
    forever begin
      @(posedge CLK); #2;
      if (send_trigger && !busy && !hold_busy_low) begin
        d = $urandom_range(0, 2);
        for (int i = 0; i < d; i++) begin
          @(posedge CLK); #2;
          chk("trig_hold", 128'(send_trigger), 128'd1);
        end
        busy = 1'b1;
        @(posedge CLK); #2;
        chk("trig_drop", 128'(send_trigger), 128'd0);
        d = $urandom_range(0, 2);
        repeat (d) @(posedge CLK);
        busy = 1'b0;
        done_cnt++;
      end
    end
  end

  // issue one command through the model and the DUT, then check architectural state
  task automatic do_cmd(input logic [15:0] cmd, input logic [127:0] payload);
    logic [3:0]   op;
    logic [2:0]   a;
    logic [7:0]   d;
    logic [7:0]   byte_v;
    logic [127:0] one;
    int           n;
    int           tgt;
    bit           armed;
    exp_t         e;
    op = cmd[15:12]; a = cmd[10:8]; d = cmd[7:0]; n = int'(cmd[4:0]);
    one = 128'd1;
    tgt = done_cnt;
    armed = 1'b0;
    case (op)
      4'h1: if (a != 3'd7) m_regs[a] = d; else bump_err();
      4'h2: begin
        byte_v = (a == 3'd7) ? stat_in : m_regs[a];
        e.data = 128'd8192 + 128'(a) * 128'd256 + 128'(byte_v);
        e.typ = 3'b010; e.cnt = 7'(m_ibc);
        exp_q.push_back(e); tgt++;
      end
      4'h3: if (n >= 1 && n <= 16) begin m_ibc = n; armed = 1'b1; end else bump_err();
      4'h4: if (m_lcnt == 0) bump_err();
            else begin
              e.data = m_lbuf; e.typ = 3'b111; e.cnt = 7'(m_lcnt);
              exp_q.push_back(e); tgt++; m_ibc = m_lcnt;
            end
      default: bump_err();
    endcase
    pulse(cmd);
    if (armed) begin
      @(posedge CLK); #1;
      chk("long_arm", 128'(LongMsgComing), 128'd1);
      chk("long_cnt", 128'(InMsgByteCount), 128'(n));
      long_dataIN = payload;
      m_lbuf = payload & ((one << (8 * n)) - one);
      m_lcnt = n;
      pulse(16'h0000);
      chk("long_disarm", 128'(LongMsgComing), 128'd0);
    end
    if (tgt > done_cnt) begin
      @(posedge CLK); #1;
      chk("latency_c1", 128'(send_trigger), 128'd0);
      @(posedge CLK); #1;
      chk("latency_c2", 128'(send_trigger), 128'd1);
      for (int i = 0; i < 100 && done_cnt < tgt; i++) @(posedge CLK);
      if (done_cnt < tgt) begin
        checks++; errors++;
        $display("FAIL reply_timeout: got %0d replies expected %0d", done_cnt, tgt);
      end
    end
    repeat (2) @(posedge CLK); #1;
    chk("reg_out", 128'(reg_out), 128'(m_regout()));
    chk("err_cnt", 128'(err_cnt), 128'(m_err));
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    logic [3:0]  op;
    RST = 1'b0; received = 1'b0; received_data = 48'd0; long_dataIN = 128'd0; stat_in = 8'hA5;
    model_reset();
    repeat (3) @(posedge CLK); #1;
    chk("rst_trig", 128'(send_trigger), 128'd0);
    chk("rst_type", 128'(SPI_MSG_TYPE), 128'd2);
    chk("rst_out",  output_data, 128'd0);
    chk("rst_lmc",  128'(LongMsgComing), 128'd0);
    chk("rst_ibc",  128'(InMsgByteCount), 128'd0);
    chk("rst_regs", 128'(reg_out), 128'd0);
    chk("rst_err",  128'(err_cnt), 128'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // directed examples
    do_cmd(16'h135A, 128'd0);
    chk("r3_5a", 128'(reg_out[31:24]), 128'h5A);
    do_cmd(16'h2300, 128'd0);
    chk("read_r3", 128'(output_data[15:0]), 128'h235A);
    do_cmd(16'h3004, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEAD_BEEF});
    do_cmd(16'h4000, 128'd0);
    chk("long_rd", output_data, 128'hDEAD_BEEF);
    do_cmd(16'hF000, 128'd0);
    do_cmd(16'h3000, 128'd0);
    do_cmd(16'h17AB, 128'd0);
    chk("err3", 128'(err_cnt), 128'd3);

    // a frame landing exactly as the FSM returns to IDLE is still decoded
    m_regs[1] = 8'h11; m_regs[2] = 8'h22;
    pulse(16'h1111);
    pulse(16'h1222);
    repeat (3) @(posedge CLK); #1;
    chk("b2b_regs", 128'(reg_out), 128'(m_regout()));
    chk("b2b_err",  128'(err_cnt), 128'(m_err));

    // a frame arriving mid-reply is dropped and counted
    do_cmd(16'h2100, 128'd0);
    stat_in = 8'h3C;
    begin
      exp_t e;
      e.data = 128'h273C; e.typ = 3'b010; e.cnt = 7'(m_ibc);
      exp_q.push_back(e);
    end
    pulse(16'h2700);
    @(posedge CLK); #1;
    pulse(16'h10EE);
    bump_err();
    for (int i = 0; i < 100 && busy == 1'b0; i++) @(posedge CLK);
    for (int i = 0; i < 100 && busy == 1'b1; i++) @(posedge CLK);
    repeat (3) @(posedge CLK); #1;
    chk("drop_regs", 128'(reg_out), 128'(m_regout()));
    chk("drop_err",  128'(err_cnt), 128'(m_err));

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      c = 16'($urandom());
      case ($urandom_range(0, 4))
        0: op = 4'h1;
        1: op = 4'h2;
        2: op = 4'h3;
        3: op = 4'h4;
        default: op = 4'($urandom());
      endcase
      c[15:12] = op;
      if (op == 4'h3 && $urandom_range(0, 3) != 0) c[4:0] = 5'($urandom_range(1, 16));
      stat_in = 8'($urandom());
      do_cmd(c, {$urandom(), $urandom(), $urandom(), $urandom()});
    end

    // error counter saturation
    for (int i = 0; i < 260; i++) begin
      pulse(16'hF000);
      bump_err();
      repeat (2) @(posedge CLK); #1;
    end
    chk("err_sat", 128'(err_cnt), 128'd255);

    // reset while waiting for the slave to acknowledge
    hold_busy_low = 1'b1;
    stat_in = 8'h5A;
    begin
      exp_t e;
      e.data = 128'h2000 + 128'(m_regs[0]); e.typ = 3'b010; e.cnt = 7'(m_ibc);
      exp_q.push_back(e);
    end
    pulse(16'h2000);
    repeat (3) @(posedge CLK); #1;
    chk("ack_wait_trig", 128'(send_trigger), 128'd1);
    #2 RST = 1'b0;
    #1;
    model_reset();
    chk("arst_trig", 128'(send_trigger), 128'd0);
    chk("arst_type", 128'(SPI_MSG_TYPE), 128'd2);
    chk("arst_out",  output_data, 128'd0);
    chk("arst_ibc",  128'(InMsgByteCount), 128'd0);
    chk("arst_regs", 128'(reg_out), 128'd0);
    chk("arst_err",  128'(err_cnt), 128'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    hold_busy_low = 1'b0;
    repeat (5) @(posedge CLK); #1;
    chk("post_rst_trig", 128'(send_trigger), 128'd0);
    do_cmd(16'h4000, 128'd0);

`ifdef SPI_CMD_TIMEOUT_EN
    m_ibc = 4;
    pulse(16'h3004);
    repeat (50) @(posedge CLK); #1;
    chk("tmo_armed", 128'(LongMsgComing), 128'd1);
    repeat (55) @(posedge CLK); #1;
    bump_err();
    chk("tmo_lmc", 128'(LongMsgComing), 128'd0);
    chk("tmo_err", 128'(err_cnt), 128'(m_err));
    do_cmd(16'h4000, 128'd0);
`endif

    repeat (5) @(posedge CLK); #1;
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
- REQ-001: Parameter TMO_CYCLES, default 1000000, sets the long-payload timeout in CLK cycles (range 1..2^20-1).
- REQ-002: CLK  in  1  system clock; all logic SHALL be on its rising edge.
- REQ-003: RST  in  1  reset; asynchronous assert, active-low (0 = reset).
- REQ-004: received  in  1  one-cycle pulse from the SPI slave: a frame is complete.
- REQ-005: received_data  in  48  short frame; command in bits [15:0].
- REQ-006: long_dataIN  in  128  long payload, right-aligned, N bytes in bits [8N-1:0].
- REQ-007: busy  in  1  SPI slave busy.
- REQ-008: stat_in  in  8  read-only status byte from the application.
- REQ-009: send_trigger  out  1  request to the SPI slave to transmit.
- REQ-010: SPI_MSG_TYPE  out  3  response type: 3'b010 = two bytes, 3'b111 = long.
- REQ-011: output_data  out  128  response data, right-aligned.
- REQ-012: LongMsgComing  out  1  next frame is a long payload.
- REQ-013: InMsgByteCount  out  7  long frame length in bytes (1..16).
- REQ-014: reg_out  out  64  registers R0..R7; Rk occupies bits [8k+7:8k].
- REQ-015: err_cnt  out  8  count of errors; saturates at 255.

Function
- REQ-016: Command word cmd = received_data[15:0] SHALL be decoded as opcode = cmd[15:12], addr = cmd[10:8], data = cmd[7:0]; cmd[11] is ignored.
- REQ-017: FSM states SHALL be IDLE, DECODE, WAIT_LONG, TRIG, WAIT_ACK and WAIT_DONE.
- REQ-018: IDLE SHALL go to DECODE on received=1, capturing cmd in the same cycle.
- REQ-019: WRITE (opcode 1), DECODE: if addr≠7, write Rk <= data; if addr=7, increment err_cnt; then go to IDLE.
- REQ-020: READ (opcode 2), DECODE: output_data <= {112'b0, 4'h2, 1'b0, addr, byte}, where byte = stat_in when addr=7, otherwise Rk; SPI_MSG_TYPE <= 3'b010; then go to TRIG.
- REQ-021: LONG_WR (opcode 3), DECODE: let N = data[4:0]. If N is in 1..16, set LongMsgComing=1 and InMsgByteCount=N, then go to WAIT_LONG. Otherwise increment err_cnt and go to IDLE.
- REQ-022: WAIT_LONG, on received=1: lbuf <= long_dataIN with bits [127:8N] forced to 0; lcnt <= N; LongMsgComing <= 0; go to IDLE.
- REQ-023: LONG_RD (opcode 4), DECODE: if lcnt=0, increment err_cnt and go to IDLE. Otherwise output_data <= lbuf, SPI_MSG_TYPE <= 3'b111, InMsgByteCount <= lcnt, then go to TRIG.
- REQ-024: Any other opcode SHALL increment err_cnt and return to IDLE.
- REQ-025: TRIG SHALL wait for busy=0, then assert send_trigger and go to WAIT_ACK.
- REQ-026: WAIT_ACK SHALL hold send_trigger=1 until busy=1, then deassert send_trigger and go to WAIT_DONE.
- REQ-027: WAIT_DONE SHALL return to IDLE when busy=0.
- REQ-028: output_data, SPI_MSG_TYPE and InMsgByteCount SHALL be stable from TRIG through WAIT_DONE.
- REQ-029: A received pulse outside IDLE and WAIT_LONG SHALL be dropped and SHALL increment err_cnt.
- REQ-030: If a READ or WRITE receives received=1 in the same cycle as the FSM enters IDLE, the command SHALL be decoded normally; it SHALL not be lost.
- REQ-031: err_cnt SHALL saturate at 8'hFF, with no wrap to 0.
- REQ-032: Latency from the received pulse to send_trigger=1 SHALL be 2 CLK cycles when busy=0.

Reset
- REQ-033: On RST=0: FSM to IDLE; send_trigger=0, LongMsgComing=0, SPI_MSG_TYPE=3'b010, InMsgByteCount=0, output_data=0, reg_out=0, err_cnt=0, lbuf=0, lcnt=0.
- REQ-034: Reset SHALL take effect immediately in any state; a pending transmit or long arm SHALL be abandoned without a further send_trigger.

Configuration
- REQ-035: Macro SPI_CMD_TIMEOUT_EN defined: a 20-bit counter SHALL start on entry to WAIT_LONG. If it reaches TMO_CYCLES before received=1, the block SHALL clear LongMsgComing, increment err_cnt and go to IDLE; lbuf and lcnt are unchanged.
- REQ-036: Macro undefined: the counter SHALL not exist, and WAIT_LONG SHALL wait indefinitely.

Verification
- REQ-037: WRITE cmd 16'h1_3_5A -> reg_out[31:24]=8'h5A one cycle after DECODE; err_cnt unchanged.
- REQ-038: READ cmd 16'h2_3_00 after REQ-037 -> send_trigger=1 two cycles after received; output_data[15:0]=16'h235A; SPI_MSG_TYPE=3'b010; send_trigger held until busy=1 and dropped the cycle after.
- REQ-039: LONG_WR cmd 16'h3_0_04, then received with long_dataIN=128'hFFFF_..._DEADBEEF -> LongMsgComing=1 and InMsgByteCount=4 in between, then LongMsgComing=0. A following LONG_RD 16'h4_0_00 -> output_data=128'hDEADBEEF, SPI_MSG_TYPE=3'b111, InMsgByteCount=4.
- REQ-040: Opcode 4'hF, then LONG_WR with N=0, then WRITE to addr 7 -> err_cnt=3; no send_trigger; reg_out unchanged.
- REQ-041: RST=0 pulsed while in WAIT_ACK -> send_trigger=0 at once and all outputs at reset values. With SPI_CMD_TIMEOUT_EN defined and TMO_CYCLES=100, LONG_WR with no payload -> LongMsgComing=0 and err_cnt=1 after 100 cycles.
